// File: rtl/bpfcap_pkt_reader.sv
// bpfcap_pkt_reader: Avalon-MM burst read master that pulls one captured packet
// out of packet memory and streams it word by word to the BPF filter engine.
// A credit scheme keeps the sum of buffered and in-flight words within the
// output FIFO, so every returning read word always has a slot waiting for it.
module bpfcap_pkt_reader #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int BURST_MAX  = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int BC_W      = $clog2(BURST_MAX) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] pkt_addr,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [BC_W-1:0]   avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        out_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CR_W  = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  req_left;
  logic [LEN_W-1:0]  out_left;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [1:0]        empty_q;
  logic              done_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic [LEN_W:0]    len_p3;
  logic [LEN_W-1:0]  start_words;
  logic [BC_W-1:0]   bc;
  logic [CR_W-1:0]   need;
  logic              credit_ok;
  logic              last_burst;
  logic              start_go;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;

  // Word count, burst size and credit are derived from the latched packet state;
  // credit counts both buffered words and words already requested but not yet returned.
  always_comb begin
    len_p3      = {1'b0, pkt_len} + (LEN_W + 1)'(3);
    start_words = LEN_W'(len_p3 >> 2);
    bc          = (req_left >= LEN_W'(BURST_MAX)) ? BC_W'(BURST_MAX) : req_left[BC_W-1:0];
    need        = CR_W'(fifo_cnt) + CR_W'(outstanding) + CR_W'(bc);
    credit_ok   = (need <= CR_W'(FIFO_DEPTH));
    last_burst  = (req_left == LEN_W'(bc));
    start_go    = start && (pkt_addr[1:0] == 2'b00) && (pkt_len != '0);
    fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    out_valid   = (fifo_cnt != '0);
    out_data    = out_valid ? mem[rd_ptr] : '0;
    out_last    = out_valid && (out_left == LEN_W'(1));
    out_empty   = out_last ? empty_q : 2'b00;
    pop         = out_valid && out_ready;
    accept      = avm_read && !avm_waitrequest;
    push        = avm_readdatavalid && (state != S_IDLE);
    avm_address = addr_q;
    done        = done_q;
    err         = err_q;
  end

  // Next-state logic plus the bus request, which is held steady for the whole REQ stay.
  always_comb begin
    state_nxt      = state;
    avm_read       = 1'b0;
    avm_burstcount = '0;
    busy           = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_go) state_nxt = S_REQ;
      end
      S_REQ: begin
        avm_read       = 1'b1;
        avm_burstcount = bc;
        if (!avm_waitrequest) state_nxt = last_burst ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (credit_ok) state_nxt = S_REQ;
      end
      S_DRAIN: begin
        if (pop && out_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Packet bookkeeping: latch on start, advance address on each accepted burst, count handoffs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      req_left    <= '0;
      out_left    <= '0;
      outstanding <= '0;
      empty_q     <= 2'b00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == S_IDLE && start) begin
        if (pkt_addr[1:0] != 2'b00) begin
          err_q <= 1'b1;
        end else if (pkt_len == '0) begin
          done_q <= 1'b1;
        end else begin
          addr_q   <= pkt_addr;
          req_left <= start_words;
          out_left <= start_words;
          empty_q  <= 2'b00 - pkt_len[1:0];
        end
      end
      if (accept) begin
        addr_q   <= addr_q + ADDR_W'({bc, 2'b00});
        req_left <= req_left - LEN_W'(bc);
      end
      if (pop) out_left <= out_left - LEN_W'(1);
      if (state == S_DRAIN && pop && out_last) done_q <= 1'b1;
      outstanding <= outstanding + (accept ? CNT_W'(bc) : CNT_W'(0)) - (push ? CNT_W'(1) : CNT_W'(0));
    end
  end

  // FIFO storage; not reset because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credit accounting must make a write into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_bpfcap_pkt_reader.sv
// tb_bpfcap_pkt_reader: directed scenarios for the packet reader with a
// latency-1 Avalon burst slave model and a stream monitor on the output side.
module tb_bpfcap_pkt_reader;

  localparam int BURST_MAX  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int BC_W       = $clog2(BURST_MAX) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            start = 1'b0;
  logic [31:0]     pkt_addr = '0;
  logic [15:0]     pkt_len = '0;
  logic            busy;
  logic            done;
  logic            err;
  logic [31:0]     avm_address;
  logic            avm_read;
  logic [BC_W-1:0] avm_burstcount;
  logic            avm_waitrequest = 1'b0;
  logic [31:0]     avm_readdata = '0;
  logic            avm_readdatavalid = 1'b0;
  logic [31:0]     out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic [1:0]      out_empty;

  int n_cmp = 0;
  int n_fail = 0;

  bpfcap_pkt_reader #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(16), .BURST_MAX(BURST_MAX), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pkt_addr(pkt_addr), .pkt_len(pkt_len),
    .busy(busy), .done(done), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_empty(out_empty)
  );

  always #5 clk = ~clk;

  // Contents of packet memory: each word is a distinct function of its byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Slave model: log accepted bursts, return one word per cycle starting the cycle after accept.
  logic [31:0] pend_q[$];
  logic [31:0] burst_addr[$];
  int          burst_cnt[$];
  int          acc_words = 0;
  int          read_cycles = 0;
  always begin
    @(negedge clk);
    if (avm_read) read_cycles++;
    if (avm_read && !avm_waitrequest) begin
      burst_addr.push_back(avm_address);
      burst_cnt.push_back(int'(avm_burstcount));
      acc_words += int'(avm_burstcount);
      for (int i = 0; i < int'(avm_burstcount); i++) pend_q.push_back(avm_address + 32'(4 * i));
    end
    @(posedge clk);
    #1;
    if (pend_q.size() > 0) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(pend_q.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
    end
  end

  // Monitor: record every handoff and the done/err pulses with their cycle numbers.
  logic [31:0] mon_data[$];
  logic        mon_last[$];
  logic [1:0]  mon_empty[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          last_cyc = -1;
  int          done_cyc = -1;
  logic        busy_at_done = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (out_valid && out_ready) begin
      mon_data.push_back(out_data);
      mon_last.push_back(out_last);
      mon_empty.push_back(out_empty);
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (err) err_cnt++;
  end

  task automatic start_pkt(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    pkt_addr = a;
    pkt_len  = l;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s_done_timeout: no done within %0d cycles, required a done pulse", tag, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, avm_read, avm_address, avm_burstcount, out_data, out_valid, out_last, out_empty} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: busy=%b read=%b addr=%h bc=%0d valid=%b data=%h, required all 0",
               busy, avm_read, avm_address, avm_burstcount, out_valid, out_data);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int wb, bb, eb, nl;
    out_ready = 1'b1;
    wb = mon_data.size(); bb = burst_addr.size(); eb = err_cnt;
    start_pkt(32'h100, 16'd64);
    n_cmp++;
    if ({busy, avm_read} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL basic_first_read: busy,read=%b required 11", {busy, avm_read});
    end
    start_pkt(32'h7, 16'd4);
    wait_done(300, "basic");
    n_cmp++;
    if (err_cnt - eb !== 0) begin
      n_fail++; $display("[TB] FAIL basic_start_while_busy: err pulses=%0d required 0", err_cnt - eb);
    end
    n_cmp++;
    if (burst_addr.size() - bb !== 2) begin
      n_fail++; $display("[TB] FAIL basic_bursts: got %0d bursts required 2", burst_addr.size() - bb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (burst_addr[bb+i] !== 32'h100 + 32'(32 * i) || burst_cnt[bb+i] !== 8) begin
          n_fail++; $display("[TB] FAIL basic_burst%0d: addr=%h cnt=%0d required addr=%h cnt=8",
                             i, burst_addr[bb+i], burst_cnt[bb+i], 32'h100 + 32'(32 * i));
        end
      end
    end
    n_cmp++;
    if (mon_data.size() - wb !== 16) begin
      n_fail++; $display("[TB] FAIL basic_word_count: got %0d required 16", mon_data.size() - wb);
    end else begin
      nl = 0;
      for (int i = 0; i < 16; i++) begin
        if (mon_last[wb+i]) nl++;
        n_cmp++;
        if (mon_data[wb+i] !== mem_word(32'h100 + 32'(4 * i))) begin
          n_fail++; $display("[TB] FAIL basic_data%0d: got %h required %h", i, mon_data[wb+i], mem_word(32'h100 + 32'(4 * i)));
        end
      end
      n_cmp++;
      if (nl !== 1 || mon_last[wb+15] !== 1'b1 || mon_empty[wb+15] !== 2'd0) begin
        n_fail++; $display("[TB] FAIL basic_last: last count=%0d last16=%b empty=%0d required 1/1/0",
                           nl, mon_last[wb+15], mon_empty[wb+15]);
      end
    end
    n_cmp++;
    if (done_cyc - last_cyc !== 1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_done_timing: done-last=%0d busy=%b required 1/0", done_cyc - last_cyc, busy_at_done);
    end
  endtask

  task automatic test_short();
    int wb, bb;
    out_ready = 1'b1;
    wb = mon_data.size(); bb = burst_addr.size();
    start_pkt(32'h200, 16'd13);
    wait_done(100, "short");
    n_cmp++;
    if (burst_addr.size() - bb !== 1 || burst_cnt[bb] !== 4 || burst_addr[bb] !== 32'h200) begin
      n_fail++; $display("[TB] FAIL short_burst: bursts=%0d required one 4-word burst at 200", burst_addr.size() - bb);
    end
    n_cmp++;
    if (mon_data.size() - wb !== 4) begin
      n_fail++; $display("[TB] FAIL short_word_count: got %0d required 4", mon_data.size() - wb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (mon_data[wb+i] !== mem_word(32'h200 + 32'(4 * i)) || mon_last[wb+i] !== (i == 3)) begin
          n_fail++; $display("[TB] FAIL short_word%0d: data=%h last=%b required %h/%b",
                             i, mon_data[wb+i], mon_last[wb+i], mem_word(32'h200 + 32'(4 * i)), i == 3);
        end
      end
      n_cmp++;
      if (mon_empty[wb+3] !== 2'd3) begin
        n_fail++; $display("[TB] FAIL short_empty: got %0d required 3", mon_empty[wb+3]);
      end
    end
  endtask

  task automatic test_zero_len();
    int rb, wb;
    rb = read_cycles; wb = mon_data.size();
    start_pkt(32'h300, 16'd0);
    n_cmp++;
    if ({done, busy, err} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL zero_done: done,busy,err=%b required 100", {done, busy, err});
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (read_cycles !== rb || busy !== 1'b0 || done !== 1'b0 || mon_data.size() !== wb) begin
      n_fail++; $display("[TB] FAIL zero_quiet: read cycles=%0d busy=%b done=%b required 0/0/0",
                         read_cycles - rb, busy, done);
    end
  endtask

  task automatic test_unaligned();
    int rb, eb;
    rb = read_cycles; eb = err_cnt;
    start_pkt(32'h102, 16'd64);
    n_cmp++;
    if ({err, busy, done} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL unaligned_err: err,busy,done=%b required 100", {err, busy, done});
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (read_cycles !== rb || busy !== 1'b0 || err_cnt - eb !== 1) begin
      n_fail++; $display("[TB] FAIL unaligned_quiet: read cycles=%0d busy=%b err pulses=%0d required 0/0/1",
                         read_cycles - rb, busy, err_cnt - eb);
    end
  endtask

  task automatic test_backpressure();
    int wb, ab, nl;
    out_ready = 1'b0;
    wb = mon_data.size(); ab = acc_words;
    start_pkt(32'h1000, 16'd256);
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (acc_words - ab > FIFO_DEPTH || acc_words - ab < BURST_MAX) begin
      n_fail++; $display("[TB] FAIL bp_requested: %0d words requested, required %0d..%0d", acc_words - ab, BURST_MAX, FIFO_DEPTH);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== mem_word(32'h1000) || out_last !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bp_hold: valid=%b data=%h last=%b required 1/%h/0", out_valid, out_data, out_last, mem_word(32'h1000));
    end
    out_ready = 1'b1;
    wait_done(800, "bp");
    n_cmp++;
    if (mon_data.size() - wb !== 64) begin
      n_fail++; $display("[TB] FAIL bp_word_count: got %0d required 64", mon_data.size() - wb);
    end else begin
      nl = 0;
      for (int i = 0; i < 64; i++) begin
        if (mon_last[wb+i]) nl++;
        n_cmp++;
        if (mon_data[wb+i] !== mem_word(32'h1000 + 32'(4 * i))) begin
          n_fail++; $display("[TB] FAIL bp_data%0d: got %h required %h", i, mon_data[wb+i], mem_word(32'h1000 + 32'(4 * i)));
        end
      end
      n_cmp++;
      if (nl !== 1 || mon_last[wb+63] !== 1'b1 || mon_empty[wb+63] !== 2'd0) begin
        n_fail++; $display("[TB] FAIL bp_last: last count=%0d last64=%b empty=%0d required 1/1/0", nl, mon_last[wb+63], mon_empty[wb+63]);
      end
    end
  endtask

  task automatic test_waitreq();
    int wb, bb;
    out_ready = 1'b1;
    avm_waitrequest = 1'b1;
    wb = mon_data.size(); bb = burst_addr.size();
    start_pkt(32'h400, 16'd32);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({avm_read, avm_address, avm_burstcount} !== {1'b1, 32'h400, BC_W'(8)}) begin
        n_fail++; $display("[TB] FAIL wait_stable%0d: read=%b addr=%h bc=%0d required 1/400/8", i, avm_read, avm_address, avm_burstcount);
      end
    end
    @(posedge clk); #1;
    avm_waitrequest = 1'b0;
    wait_done(100, "wait");
    n_cmp++;
    if (burst_addr.size() - bb !== 1 || burst_addr[bb] !== 32'h400 || burst_cnt[bb] !== 8) begin
      n_fail++; $display("[TB] FAIL wait_burst: bursts=%0d required one 8-word burst at 400", burst_addr.size() - bb);
    end
    n_cmp++;
    if (mon_data.size() - wb !== 8 || mon_data[wb+7] !== mem_word(32'h41C) || mon_last[wb+7] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL wait_words: count=%0d required 8 words ending at %h with last", mon_data.size() - wb, mem_word(32'h41C));
    end
  endtask

  task automatic test_reset_mid();
    int db, wb, bb;
    out_ready = 1'b1;
    db = done_cnt;
    start_pkt(32'h800, 16'd64);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rmid_busy: busy=%b required 1", busy);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, avm_read, avm_address, avm_burstcount, out_data, out_valid, out_last, out_empty} !== '0) begin
      n_fail++; $display("[TB] FAIL rmid_outputs: busy=%b read=%b addr=%h bc=%0d valid=%b data=%h, required all 0",
                         busy, avm_read, avm_address, avm_burstcount, out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wb = mon_data.size();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mon_data.size() !== wb || done_cnt !== db) begin
      n_fail++; $display("[TB] FAIL rmid_idle: valid=%b busy=%b late handoffs=%0d done pulses=%0d required 0/0/0/0",
                         out_valid, busy, mon_data.size() - wb, done_cnt - db);
    end
    bb = burst_addr.size();
    start_pkt(32'h900, 16'd18);
    wait_done(100, "rmid");
    n_cmp++;
    if (burst_addr.size() - bb !== 1 || burst_cnt[bb] !== 5 || burst_addr[bb] !== 32'h900) begin
      n_fail++; $display("[TB] FAIL rmid_burst: bursts=%0d required one 5-word burst at 900", burst_addr.size() - bb);
    end
    n_cmp++;
    if (mon_data.size() - wb !== 5) begin
      n_fail++; $display("[TB] FAIL rmid_word_count: got %0d required 5", mon_data.size() - wb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (mon_data[wb+i] !== mem_word(32'h900 + 32'(4 * i)) || mon_last[wb+i] !== (i == 4)) begin
          n_fail++; $display("[TB] FAIL rmid_word%0d: data=%h last=%b required %h/%b",
                             i, mon_data[wb+i], mon_last[wb+i], mem_word(32'h900 + 32'(4 * i)), i == 4);
        end
      end
      n_cmp++;
      if (mon_empty[wb+4] !== 2'd2) begin
        n_fail++; $display("[TB] FAIL rmid_empty: got %0d required 2", mon_empty[wb+4]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_zero_len();
    test_unaligned();
    test_backpressure();
    test_waitreq();
    test_reset_mid();
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
